pc_unit: RTL

- Parametrised program-counter unit for the single-cycle/multi-cycle MIPS datapath. Successor to the plain PC register.
- Holds the PC and computes the next PC from sequential, branch, jump and jump-register sources.
- Supports stall and instruction-memory back-pressure, and queues a redirect that arrives while the PC is held.
- Drives the instruction-memory address and the PC+4 value used by the link/branch logic.

---
 rtl/pc_unit_if.sv | 41 ++++
 rtl/pc_unit.sv | 122 ++++++++++++
 2 files changed

// File: rtl/pc_unit_if.sv
// Fetch-side bus of pc_unit: stall/back-pressure and redirect requests in, fetch address out.
// With PC_EXC_EN defined the bus also carries Exc_Req, Eret and EPC.
interface pc_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             Stall;
  logic             Imem_Ready;
  logic             Br_Taken;
  logic [15:0]      Br_Offset;
  logic             J_Taken;
  logic [25:0]      J_Index;
  logic             Jr_Taken;
  logic [WIDTH-1:0] Jr_Target;
  logic [WIDTH-1:0] PC;
  logic [WIDTH-1:0] PC_Plus4;
  logic             Fetch_Valid;
  logic             Misalign_Err;
`ifdef PC_EXC_EN
  logic             Exc_Req;
  logic             Eret;
  logic [WIDTH-1:0] EPC;
`endif

  modport master (
`ifdef PC_EXC_EN
    output Exc_Req, Eret,
    input  EPC,
`endif
    output Stall, Imem_Ready, Br_Taken, Br_Offset, J_Taken, J_Index, Jr_Taken, Jr_Target,
    input  PC, PC_Plus4, Fetch_Valid, Misalign_Err
  );

  modport slave (
`ifdef PC_EXC_EN
    input  Exc_Req, Eret,
    output EPC,
`endif
    input  Stall, Imem_Ready, Br_Taken, Br_Offset, J_Taken, J_Index, Jr_Taken, Jr_Target,
    output PC, PC_Plus4, Fetch_Valid, Misalign_Err
  );
endinterface

// File: rtl/pc_unit.sv
// MIPS program-counter unit: sequential/branch/jump/jr next-PC with stall, back-pressure and a
// one-deep redirect queue. Optional exception entry/return when PC_EXC_EN is defined.
module pc_unit #(
  parameter int unsigned WIDTH     = 32,
  parameter logic [31:0] RESET_VEC = 32'h0000_3000
`ifdef PC_EXC_EN
  ,
  parameter logic [31:0] EXC_VEC   = 32'h0000_4180
`endif
) (
  input logic      Clk,
  input logic      Rst,
  pc_unit_if.slave bus
);
  localparam int unsigned SEXT_W = WIDTH - 18;

  typedef enum logic [1:0] {
    RST_HOLD = 2'd0,
    RUN      = 2'd1,
    PEND     = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             fetch_valid_q;
  logic             misalign_q, misalign_d;
  logic [WIDTH-1:0] pc_plus4, br_tgt, j_tgt, jr_tgt, redir_tgt;
  logic             redir, jr_win, advance;
`ifdef PC_EXC_EN
  logic [WIDTH-1:0] epc_q, epc_d;
`endif

  assign pc_plus4 = pc_q + WIDTH'(4);
  assign br_tgt   = pc_plus4 + {{SEXT_W{bus.Br_Offset[15]}}, bus.Br_Offset, 2'b00};
  assign j_tgt    = {pc_plus4[WIDTH-1:28], bus.J_Index, 2'b00};
  assign jr_tgt   = {bus.Jr_Target[WIDTH-1:2], 2'b00};
  assign advance  = (state_q != RST_HOLD) && !bus.Stall && bus.Imem_Ready;

  // Redirect source select; lower-priority requests in the same cycle are dropped
  always_comb begin
    redir     = 1'b1;
    jr_win    = 1'b0;
    redir_tgt = pc_plus4;
`ifdef PC_EXC_EN
    if (bus.Eret) redir_tgt = epc_q;
    else
`endif
    if (bus.Jr_Taken) begin
      jr_win    = 1'b1;
      redir_tgt = jr_tgt;
    end else if (bus.J_Taken) begin
      redir_tgt = j_tgt;
    end else if (bus.Br_Taken) begin
      redir_tgt = br_tgt;
    end else begin
      redir = 1'b0;
    end
  end

  // Next-state / next-PC; a redirect seen while held overwrites the queued one
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_d     = pend_q;
    misalign_d = 1'b0;
`ifdef PC_EXC_EN
    epc_d      = epc_q;
    if (bus.Exc_Req) begin
      state_d = RUN;
      pc_d    = WIDTH'(EXC_VEC);
      pend_d  = '0;
      epc_d   = pc_q;
    end else
`endif
    if (state_q == RST_HOLD) begin
      state_d = RUN;
    end else begin
      misalign_d = jr_win && (bus.Jr_Target[1:0] != 2'b00);
      if (advance) begin
        if (redir)                 pc_d = redir_tgt;
        else if (state_q == PEND)  pc_d = pend_q;
        else                       pc_d = pc_plus4;
        pend_d  = '0;
        state_d = RUN;
      end else if (redir) begin
        pend_d  = redir_tgt;
        state_d = PEND;
      end
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q       <= RST_HOLD;
      pc_q          <= WIDTH'(RESET_VEC);
      pend_q        <= '0;
      fetch_valid_q <= 1'b0;
      misalign_q    <= 1'b0;
`ifdef PC_EXC_EN
      epc_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_q        <= pend_d;
      fetch_valid_q <= (state_d != RST_HOLD);
      misalign_q    <= misalign_d;
`ifdef PC_EXC_EN
      epc_q         <= epc_d;
`endif
    end
  end

  assign bus.PC           = pc_q;
  assign bus.PC_Plus4     = pc_plus4;
  assign bus.Fetch_Valid  = fetch_valid_q;
  assign bus.Misalign_Err = misalign_q;
`ifdef PC_EXC_EN
  assign bus.EPC          = epc_q;
`endif
endmodule
